// File: rtl/prach_buffer_reader_pkg.sv
// Shared types for the PRACH buffer readout path: sample format, stream tag and reader FSM states.
// Pure declarations; no logic.
package prach_buffer_reader_pkg;

    localparam int PRACH_N_SAMPLES = 1536;
    localparam int ADDR_W          = 11;
    localparam int CH_W            = 8;

    typedef struct packed {
        logic [15:0] di;
        logic [15:0] dr;
    } sample_t;

    typedef struct packed {
        sample_t         smp;
        logic [CH_W-1:0] ch;
        logic            first;
        logic            last;
    } out_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_READ,
        ST_DRAIN
    } reader_state_t;

endpackage

// File: rtl/prach_buffer_reader_if.sv
// Capture-buffer side (done handshake, shared read port) and FFT-side sample stream of the reader.
// master = reader, slave = buffers + downstream consumer.
interface prach_buffer_reader_if #(
    parameter int NUM_CH = 4
);
    logic                 ctrl_enable;
    logic [NUM_CH-1:0]    done_req;
    logic [NUM_CH-1:0]    done_ack;
    logic [10:0]          rd_addr;
    logic [NUM_CH-1:0]    rd_en;
    logic [NUM_CH*32-1:0] rd_data;
    logic [15:0]          dout_dr;
    logic [15:0]          dout_di;
    logic [7:0]           dout_chn;
    logic                 dout_first;
    logic                 dout_last;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 busy;

    modport master (
        input  ctrl_enable, done_req, rd_data, dout_ready,
        output done_ack, rd_addr, rd_en, dout_dr, dout_di, dout_chn,
               dout_first, dout_last, dout_valid, busy
    );

    modport slave (
        output ctrl_enable, done_req, rd_data, dout_ready,
        input  done_ack, rd_addr, rd_en, dout_dr, dout_di, dout_chn,
               dout_first, dout_last, dout_valid, busy
    );
endinterface

// File: rtl/prach_buffer_reader_fifo.sv
// Sync FIFO with a registered output stage; count includes the output register. Push-to-valid 1 cycle.
// Backpressure: head holds while out_rdy=0; the producer must never push when count==DEPTH.
module prach_sync_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic [WIDTH-1:0]         in_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [WIDTH-1:0]         out_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      mem_cnt;
    logic             pop, load, bypass, from_mem, wr;

    assign pop      = out_vld && out_rdy;
    assign load     = !out_vld || pop;
    assign from_mem = load && (mem_cnt != '0);
    // Empty storage and a free head: the new entry goes straight to the output register.
    assign bypass   = load && (mem_cnt == '0) && in_vld;
    assign wr       = in_vld && !bypass;
    assign count    = mem_cnt + (AW+1)'(out_vld);

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= in_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            mem_cnt <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (wr)       wp <= wp + 1'b1;
            if (from_mem) rp <= rp + 1'b1;
            mem_cnt <= mem_cnt + (AW+1)'(wr) - (AW+1)'(from_mem);
            if (load) begin
                out_vld <= from_mem || bypass;
                if (from_mem)    out_dat <= mem[rp];
                else if (bypass) out_dat <= in_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(in_vld && count == (AW+1)'(DEPTH)));
    end
endmodule

// File: rtl/prach_buffer_reader.sv
// Acks all channel buffers once every done_req is up, then streams ch 0..NUM_CH-1 x addr 0..N_SAMPLES-1.
// Issue-to-dout_valid RD_LATENCY+1 cycles; reads are credit-limited so dout_ready=0 never drops data.
module prach_buffer_reader
    import prach_buffer_reader_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int N_SAMPLES  = PRACH_N_SAMPLES,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    prach_buffer_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reader_state_t     state;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] rd_en, done_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;

    logic              iss_vld, iss_first, iss_last;
    logic [CH_W-1:0]   iss_ch;
    logic [RD_LATENCY-1:0] pipe_vld, pipe_first, pipe_last;
    logic [CH_W-1:0]   pipe_ch [RD_LATENCY];

    logic [CW-1:0]     fifo_count;
    logic              credit_ok, ret_vld, fifo_vld;
    int                inflight;
    sample_t           ret_smp;
    out_t              push_dat, pop_dat;

    // The issue-cycle flop is in flight too: its data has not even reached the pipe yet.
    assign inflight  = $countones(pipe_vld) + int'(iss_vld);
    assign credit_ok = (int'(fifo_count) + inflight + 1) <= FIFO_DEPTH;
    assign ret_vld   = pipe_vld[RD_LATENCY-1];

    always_comb begin
        ret_smp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pipe_ch[RD_LATENCY-1] == CH_W'(c)) ret_smp = bus.rd_data[c*32 +: 32];
        end
    end

    assign push_dat = '{smp: ret_smp, ch: pipe_ch[RD_LATENCY-1],
                        first: pipe_first[RD_LATENCY-1], last: pipe_last[RD_LATENCY-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ch         <= '0;
            addr       <= '0;
            rd_en      <= '0;
            rd_addr    <= '0;
            done_ack   <= '0;
            busy       <= 1'b0;
            iss_vld    <= 1'b0;
            iss_ch     <= '0;
            iss_first  <= 1'b0;
            iss_last   <= 1'b0;
            pipe_vld   <= '0;
            pipe_first <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_ch[i] <= '0;
        end else begin
            pipe_vld[0]   <= iss_vld;
            pipe_ch[0]    <= iss_ch;
            pipe_first[0] <= iss_first;
            pipe_last[0]  <= iss_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_ch[i]    <= pipe_ch[i-1];
                pipe_first[i] <= pipe_first[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end
            iss_vld  <= 1'b0;
            rd_en    <= '0;
            done_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.ctrl_enable && (&bus.done_req)) begin
                        state    <= ST_ACK;
                        done_ack <= '1;
                        busy     <= 1'b1;
                    end
                end
                ST_ACK: begin
                    ch    <= '0;
                    addr  <= '0;
                    state <= ST_READ;
                end
                ST_READ: begin
                    if (credit_ok) begin
                        rd_en     <= NUM_CH'(1) << ch;
                        rd_addr   <= addr;
                        iss_vld   <= 1'b1;
                        iss_ch    <= ch;
                        iss_first <= (addr == '0);
                        iss_last  <= (addr == ADDR_W'(N_SAMPLES-1));
                        if (addr == ADDR_W'(N_SAMPLES-1)) begin
                            addr <= '0;
                            if (ch == CH_W'(NUM_CH-1)) state <= ST_DRAIN;
                            else                       ch    <= ch + 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!iss_vld && pipe_vld == '0 && fifo_count == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    prach_sync_fifo #(
        .WIDTH ($bits(out_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (ret_vld),
        .in_dat  (push_dat),
        .out_vld (fifo_vld),
        .out_rdy (bus.dout_ready),
        .out_dat (pop_dat),
        .count   (fifo_count)
    );

    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = rd_addr;
    assign bus.done_ack   = done_ack;
    assign bus.busy       = busy;
    assign bus.dout_valid = fifo_vld;
    assign bus.dout_dr    = pop_dat.smp.dr;
    assign bus.dout_di    = pop_dat.smp.di;
    assign bus.dout_chn   = pop_dat.ch;
    assign bus.dout_first = pop_dat.first;
    assign bus.dout_last  = pop_dat.last;
endmodule
